// File: rtl/led_bar_scheduler_pkg.sv
// Shared types and constants for the LED bar scheduler.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam int LEVEL_W   = 3;
  localparam int LEVEL_MAX = 7;
  localparam int NUM_LED   = 7;

  // Thermometer code: the lowest lvl bits set.
  function automatic logic [NUM_LED-1:0] thermometer(input logic [LEVEL_W-1:0] lvl);
    logic [NUM_LED-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      t[i] = (i < int'(lvl));
    end
    return t;
  endfunction

endpackage

// File: rtl/led_bar_scheduler_if.sv
// Control/status bundle between a sequencer host and the LED bar scheduler.
interface led_bar_scheduler_if #(
  parameter int PWM_W = 8
);
  import led_pkg::*;

  logic                 start;
  logic                 stop;
  logic                 mode;
  logic [PWM_W-1:0]     bright;
  logic [NUM_LED-1:0]   led;
  logic [LEVEL_W-1:0]   level;
  logic                 busy;
  logic                 step_tick;

  modport master (
    output start, stop, mode, bright,
    input  led, level, busy, step_tick
  );

  modport slave (
    input  start, stop, mode, bright,
    output led, level, busy, step_tick
  );

endinterface

// File: rtl/led_bar_scheduler_tick_gen.sv
// Step prescaler: counts enabled cycles and pulses tick on the last one of
// every TICK_DIV, wrapping to zero. clr wins over en.
module tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Prescaler register with synchronous reset, clear and wrap at the last count.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Tick only while counting; the owner decides whether to apply it.
  assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_bar_scheduler.sv
// LED bar-graph sequencer: steps a 0..7 level up (wrap or bounce) at a
// prescaled rate and drives a PWM-dimmed thermometer bar.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | not sequencing, bar dark, waiting for start
// UP    | level rises one segment per tick (wraps or turns at 7)
// DOWN  | bounce mode only: level falls one segment per tick to 0
module led_bar_scheduler
  import led_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int PWM_W    = 8
) (
  input  logic             clkin,
  input  logic             rst_n,
  led_bar_scheduler_if.slave bus
);

  localparam logic [LEVEL_W-1:0] LVL_TOP = LEVEL_W'(LEVEL_MAX);

  state_t               state_q, state_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 mode_q, mode_d;
  logic [PWM_W-1:0]     bright_q, bright_d;
  logic [PWM_W-1:0]     pwm_cnt_q;
  logic                 step_q, step_d;
  logic [NUM_LED-1:0]   led_q, led_d;
  logic                 presc_en, presc_clr;
  logic                 tick;
  logic                 pwm_on;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clkin (clkin),
    .rst_n (rst_n),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // State, level, latched settings, PWM counter and registered outputs.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      level_q   <= '0;
      mode_q    <= 1'b0;
      bright_q  <= '0;
      pwm_cnt_q <= '0;
      step_q    <= 1'b0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      mode_q    <= mode_d;
      bright_q  <= bright_d;
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
      step_q    <= step_d;
      led_q     <= led_d;
    end
  end

  // Next-state and level sequencing; stop outranks both start and tick.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    mode_d    = mode_q;
    bright_d  = bright_q;
    step_d    = 1'b0;
    presc_en  = (state_q != IDLE);
    presc_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d   = UP;
          level_d   = '0;
          mode_d    = bus.mode;
          bright_d  = bus.bright;
          presc_clr = 1'b1;
        end
      end

      UP: begin
        if (bus.stop) begin
          state_d   = IDLE;
          level_d   = '0;
          presc_clr = 1'b1;
        end else if (tick) begin
          step_d = 1'b1;
          if (level_q != LVL_TOP) begin
            level_d = level_q + LEVEL_W'(1);
          end else if (!mode_q) begin
            level_d = '0;
          end else begin
            state_d = DOWN;
            level_d = LVL_TOP - LEVEL_W'(1);
          end
        end
      end

      DOWN: begin
        if (bus.stop) begin
          state_d   = IDLE;
          level_d   = '0;
          presc_clr = 1'b1;
        end else if (tick) begin
          step_d = 1'b1;
          if (level_q != '0) begin
            level_d = level_q - LEVEL_W'(1);
          end else begin
            state_d = UP;
            level_d = LEVEL_W'(1);
          end
        end
      end

      default: begin
        state_d   = IDLE;
        level_d   = '0;
        presc_clr = 1'b1;
      end
    endcase
  end

  // Duty compare; all-ones brightness means fully on rather than 255/256.
  always_comb begin
    pwm_on = (&bright_q) | (pwm_cnt_q < bright_q);
  end

  // Bar drive lags level by one cycle; forced dark whenever heading to IDLE.
  always_comb begin
    led_d = '0;
    if (state_d != IDLE) begin
      led_d = thermometer(level_q) & {NUM_LED{pwm_on}};
    end
  end

  assign bus.led       = led_q;
  assign bus.level     = level_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.step_tick = step_q;

endmodule

// File: tb/tb_led_bar_scheduler.sv
// Directed bench for led_bar_scheduler: fast instance (TICK_DIV=4) for
// sequencing, slow instance (TICK_DIV=600) for PWM duty measurement.
module tb_led_bar_scheduler;
  import led_pkg::*;

  logic clkin = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clkin = ~clkin;

  led_bar_scheduler_if #(.PWM_W(8)) bus  ();
  led_bar_scheduler_if #(.PWM_W(8)) bus2 ();

  led_bar_scheduler #(.TICK_DIV(4), .PWM_W(8)) dut (
    .clkin (clkin),
    .rst_n (rst_n),
    .bus   (bus)
  );

  led_bar_scheduler #(.TICK_DIV(600), .PWM_W(8)) dut2 (
    .clkin (clkin),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  function automatic logic [6:0] therm_exp(input int n);
    logic [6:0] t;
    t = '0;
    for (int i = 0; i < n; i++) t[i] = 1'b1;
    return t;
  endfunction

  task automatic step_n(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic do_start(input logic m, input logic [7:0] b);
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.bright = b;
    step_n(1);
    bus.start  = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    step_n(1);
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1;
    step_n(2);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    checks++; if (bus.led !== 7'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", bus.led); end
    checks++; if (bus.step_tick !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", bus.step_tick); end
    checks++; if (dut.pwm_cnt_q !== 8'd0) begin errors++; $display("FAIL reset_pwm: got %0d expected 0", dut.pwm_cnt_q); end
    rst_n = 1'b1;
    bus.start = 1'b0;
    step_n(5);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_hold_idle: got busy %b expected 0", bus.busy); end
  endtask

  task automatic test_fill_wrap();
    int seq [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int prev;
    do_start(1'b0, 8'd255);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wrap_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL wrap_level0: got %0d expected 0", bus.level); end
    prev = 0;
    step_n(4);
    for (int k = 0; k < 9; k++) begin
      checks++; if (bus.level !== 3'(seq[k])) begin errors++; $display("FAIL wrap_level step %0d: got %0d expected %0d", k, bus.level, seq[k]); end
      checks++; if (bus.step_tick !== 1'b1) begin errors++; $display("FAIL wrap_step_tick step %0d: got %b expected 1", k, bus.step_tick); end
      checks++; if (bus.led !== therm_exp(prev)) begin errors++; $display("FAIL wrap_led_lag step %0d: got %h expected %h", k, bus.led, therm_exp(prev)); end
      step_n(1);
      checks++; if (bus.step_tick !== 1'b0) begin errors++; $display("FAIL wrap_step_width step %0d: got %b expected 0", k, bus.step_tick); end
      checks++; if (bus.led !== therm_exp(seq[k])) begin errors++; $display("FAIL wrap_led step %0d: got %h expected %h", k, bus.led, therm_exp(seq[k])); end
      prev = seq[k];
      step_n(3);
    end
    do_stop();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wrap_stop_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL wrap_stop_level: got %0d expected 0", bus.level); end
    checks++; if (bus.led !== 7'h00) begin errors++; $display("FAIL wrap_stop_led: got %h expected 00", bus.led); end
  endtask

  task automatic test_bounce();
    int     seq [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    state_t st  [15] = '{UP, UP, UP, UP, UP, UP, UP, DOWN, DOWN, DOWN, DOWN, DOWN, DOWN, DOWN, UP};
    int     busy_bad;
    do_start(1'b1, 8'd255);
    busy_bad = 0;
    for (int k = 0; k < 15; k++) begin
      for (int c = 0; c < 4; c++) begin
        step_n(1);
        if (bus.busy !== 1'b1) busy_bad++;
      end
      checks++; if (bus.level !== 3'(seq[k])) begin errors++; $display("FAIL bounce_level step %0d: got %0d expected %0d", k, bus.level, seq[k]); end
      checks++; if (dut.state_q !== st[k]) begin errors++; $display("FAIL bounce_state step %0d: got %0d expected %0d", k, dut.state_q, st[k]); end
      checks++; if (bus.step_tick !== 1'b1) begin errors++; $display("FAIL bounce_step_tick step %0d: got %b expected 1", k, bus.step_tick); end
    end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL bounce_busy: got %0d low samples expected 0", busy_bad); end
    do_stop();
  endtask

  task automatic test_start_stop_same();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step_n(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL startstop_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.led !== 7'h00) begin errors++; $display("FAIL startstop_led: got %h expected 00", bus.led); end
    step_n(8);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL startstop_hold: got busy %b expected 0", bus.busy); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL startstop_level: got %0d expected 0", bus.level); end
  endtask

  task automatic test_stop_on_tick();
    do_start(1'b0, 8'd255);
    step_n(12);
    checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL stoptick_pre_level: got %0d expected 3", bus.level); end
    step_n(3);
    checks++; if (dut.tick !== 1'b1) begin errors++; $display("FAIL stoptick_tick_pending: got %b expected 1", dut.tick); end
    do_stop();
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL stoptick_level: got %0d expected 0", bus.level); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stoptick_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.step_tick !== 1'b0) begin errors++; $display("FAIL stoptick_step: got %b expected 0", bus.step_tick); end
    checks++; if (bus.led !== 7'h00) begin errors++; $display("FAIL stoptick_led: got %h expected 00", bus.led); end
    step_n(1);
    checks++; if (bus.step_tick !== 1'b0) begin errors++; $display("FAIL stoptick_step_late: got %b expected 0", bus.step_tick); end
  endtask

  task automatic test_reset_mid();
    do_start(1'b1, 8'd255);
    step_n(36);
    checks++; if (bus.level !== 3'd5) begin errors++; $display("FAIL rstmid_pre_level: got %0d expected 5", bus.level); end
    checks++; if (dut.state_q !== DOWN) begin errors++; $display("FAIL rstmid_pre_state: got %0d expected DOWN", dut.state_q); end
    step_n(1);
    rst_n = 1'b0;
    step_n(1);
    rst_n = 1'b1;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected IDLE", dut.state_q); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL rstmid_level: got %0d expected 0", bus.level); end
    checks++; if (bus.led !== 7'h00) begin errors++; $display("FAIL rstmid_led: got %h expected 00", bus.led); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.step_tick !== 1'b0) begin errors++; $display("FAIL rstmid_step: got %b expected 0", bus.step_tick); end
    checks++; if (dut.u_tick.cnt_q !== 2'd0) begin errors++; $display("FAIL rstmid_presc: got %0d expected 0", dut.u_tick.cnt_q); end
    checks++; if (dut.pwm_cnt_q !== 8'd0) begin errors++; $display("FAIL rstmid_pwm: got %0d expected 0", dut.pwm_cnt_q); end
    checks++; if (dut.bright_q !== 8'd0) begin errors++; $display("FAIL rstmid_bright_q: got %0d expected 0", dut.bright_q); end
    checks++; if (dut.mode_q !== 1'b0) begin errors++; $display("FAIL rstmid_mode_q: got %b expected 0", dut.mode_q); end
    step_n(20);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_hold: got busy %b expected 0", bus.busy); end
  endtask

  task automatic test_mid_change();
    do_start(1'b0, 8'd255);
    step_n(2);
    bus.mode   = 1'b1;
    bus.bright = 8'd0;
    step_n(11);
    checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL midchg_level: got %0d expected 3", bus.level); end
    checks++; if (bus.led !== 7'h07) begin errors++; $display("FAIL midchg_led: got %h expected 07", bus.led); end
    step_n(19);
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL midchg_wrap: got %0d expected 0", bus.level); end
    do_stop();
    do_start(1'b1, 8'd0);
    step_n(29);
    checks++; if (bus.level !== 3'd7) begin errors++; $display("FAIL midchg_new_level: got %0d expected 7", bus.level); end
    checks++; if (bus.led !== 7'h00) begin errors++; $display("FAIL midchg_new_led: got %h expected 00", bus.led); end
    step_n(3);
    checks++; if (bus.level !== 3'd6) begin errors++; $display("FAIL midchg_bounce: got %0d expected 6", bus.level); end
    do_stop();
  endtask

  task automatic test_pwm();
    int n;
    int cnt [7];
    int nz;
    bus2.mode   = 1'b0;
    bus2.bright = 8'd64;
    bus2.start  = 1'b1;
    step_n(1);
    bus2.start  = 1'b0;
    n = 0;
    while (bus2.level !== 3'd7 && n < 6000) begin step_n(1); n++; end
    checks++; if (n >= 6000) begin errors++; $display("FAIL pwm64_wait: got timeout expected level 7"); end
    step_n(2);
    for (int i = 0; i < 7; i++) cnt[i] = 0;
    repeat (256) begin
      step_n(1);
      for (int i = 0; i < 7; i++) if (bus2.led[i] === 1'b1) cnt[i]++;
    end
    for (int i = 0; i < 7; i++) begin
      checks++; if (cnt[i] !== 64) begin errors++; $display("FAIL pwm64_led%0d: got %0d high cycles expected 64", i, cnt[i]); end
    end
    bus2.stop = 1'b1;
    step_n(1);
    bus2.stop   = 1'b0;
    bus2.bright = 8'd0;
    bus2.start  = 1'b1;
    step_n(1);
    bus2.start  = 1'b0;
    n = 0;
    while (bus2.level !== 3'd7 && n < 6000) begin step_n(1); n++; end
    checks++; if (n >= 6000) begin errors++; $display("FAIL pwm0_wait: got timeout expected level 7"); end
    nz = 0;
    repeat (256) begin
      step_n(1);
      if (bus2.led !== 7'h00) nz++;
    end
    checks++; if (nz !== 0) begin errors++; $display("FAIL pwm0_led: got %0d lit cycles expected 0", nz); end
    bus2.stop = 1'b1;
    step_n(1);
    bus2.stop = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0; bus.bright = '0;
    bus2.start = 1'b0; bus2.stop = 1'b0; bus2.mode = 1'b0; bus2.bright = '0;
    step_n(1);
    test_reset();
    test_fill_wrap();
    test_bounce();
    test_start_stop_same();
    test_stop_on_tick();
    test_reset_mid();
    test_mid_change();
    test_pwm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no completion expected finish before 1000000");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/led_bar_scheduler.md
LED_BAR_SCHEDULER -- requirements
Module: led_bar_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 25000000, is the number of clkin cycles per bar step; legal range is 2 or more.
REQ-002 Parameter PWM_W, default 8, is the width of the brightness value and of the PWM counter.
REQ-003 Port clkin, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset is synchronous and active-low.
REQ-005 Port start, input, 1 bit: single-cycle request to begin sequencing.
REQ-006 Port stop, input, 1 bit: single-cycle request to abort sequencing.
REQ-007 Port mode, input, 1 bit: 0 = fill-and-wrap, 1 = fill-then-drain (bounce); sampled with start.
REQ-008 Port bright, input, PWM_W bits: LED duty value; sampled with start.
REQ-009 Port led, output, 7 bits: bar-graph LED drive, registered.
REQ-010 Port level, output, 3 bits: number of lit bar segments, 0..7.
REQ-011 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 Port step_tick, output, 1 bit: one-cycle pulse in the cycle after each applied level step.

Function
REQ-013 FSM states: IDLE, UP, DOWN.
REQ-014 IDLE with start=1 and stop=0: next state is UP, level becomes 0, prescaler becomes 0, and mode and bright are latched into mode_q and bright_q.
REQ-015 The prescaler counts only in UP or DOWN; a tick occurs when it equals TICK_DIV-1, and the counter then wraps to 0.
REQ-016 UP on tick: if level < 7, level increments; if level = 7 and mode_q = 0, level becomes 0 and the state stays UP; if level = 7 and mode_q = 1, the state becomes DOWN and level becomes 6.
REQ-017 DOWN on tick: if level > 0, level decrements; if level = 0, the state becomes UP and level becomes 1.
REQ-018 stop=1 in UP or DOWN: next state is IDLE, level becomes 0 and the prescaler becomes 0.
REQ-019 Precedence: stop beats start, and stop beats tick; on a stop cycle no level update occurs and no step_tick is issued.
REQ-020 start while in UP or DOWN is ignored; mode and bright changes while running are ignored until the next start.
REQ-021 A free-running PWM_W-bit PWM counter wraps from all-ones to 0 and runs in every state.
REQ-022 pwm_on = 1 when bright_q is all-ones, otherwise pwm_on = (pwm_cnt < bright_q); bright_q = 0 gives LEDs always off.
REQ-023 led[i] <= (i < level) AND pwm_on, for i = 0..6; led has one cycle of latency from level/pwm_on.
REQ-024 In IDLE, led = 0.
REQ-025 step_tick is asserted for exactly one cycle after each level update caused by a tick.

Reset
REQ-026 rst_n=0 at a clkin edge gives: state IDLE, level 0, led 0, busy 0, step_tick 0, prescaler 0, pwm_cnt 0, bright_q 0, mode_q 0.
REQ-027 Reset asserted mid-sequence overrides start, stop and tick in the same cycle.
REQ-028 After rst_n returns high, the block sits in IDLE until a start is received.

Structure
REQ-029 A shared package, led_pkg, holds the state encoding (IDLE, UP, DOWN), LEVEL_MAX = 7 and NUM_LED = 7.
REQ-030 The prescaler is a sub-module, tick_gen, with ports clkin, rst_n, en, clr and tick, parameterized by TICK_DIV.
REQ-031 The PWM counter and comparator stay inline in led_bar_scheduler.

Verification (TICK_DIV=4, PWM_W=8 unless stated)
REQ-032 Reset, then start with mode=0 and bright=255 -> level goes 1,2,...,7 every 4 cycles, then 0, then 1; the led pattern is thermometer code of level with one cycle of lag; one step_tick per step.
REQ-033 Start with mode=1 -> level goes 0..7, then 6..0, then 1; busy stays high throughout; the state is DOWN while descending.
REQ-034 start and stop asserted together in IDLE -> stays IDLE, busy=0, led=0; stop asserted in the same cycle as a tick at level 3 -> level 0, IDLE, no step_tick.
REQ-035 bright=64 at level 7 -> each led bit is high for exactly 64 of every 256 cycles; bright=0 -> led always 0.
REQ-036 rst_n pulsed low for one cycle at level 5 during DOWN -> next cycle shows all REQ-026 values, and the block holds IDLE until start.
REQ-037 Change bright and mode mid-run -> no effect until stop followed by a new start.
